// File: rtl/fifo_ext.sv
// Parametrised synchronous FIFO with occupancy count, programmable thresholds,
// synchronous flush, overflow/underflow flags and optional empty-queue bypass.
module fifo_ext #(
  parameter int p_entry_bits   = 32,
  parameter int p_depth        = 32,
  parameter int p_almost_full  = p_depth - 1,
  parameter int p_almost_empty = 1,
  parameter bit p_bypass       = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           push,
  input  logic                           pop,
  input  logic [p_entry_bits-1:0]        wdata,
  output logic [p_entry_bits-1:0]        rdata,
  output logic                           empty,
  output logic                           full,
  output logic                           almost_full,
  output logic                           almost_empty,
  output logic [$clog2(p_depth+1)-1:0]   count,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int CW = $clog2(p_depth + 1);
  localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(p_depth);
  localparam logic [CW-1:0] AF_C    = CW'(p_almost_full);
  localparam logic [CW-1:0] AE_C    = CW'(p_almost_empty);
  localparam logic [PW-1:0] LAST_C  = PW'(p_depth - 1);

  logic [p_entry_bits-1:0] mem [p_depth];
  logic [PW-1:0]           rptr;
  logic [PW-1:0]           wptr;
  logic                    byp;
  logic                    do_push;
  logic                    do_pop;
  logic                    wr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty        = (count == '0);
    full         = (count == DEPTH_C);
    almost_full  = (count >= AF_C);
    almost_empty = (count <= AE_C);
    byp          = p_bypass && empty && push && pop;
    do_push      = push & (~full | pop) & ~flush;
    do_pop       = pop & ~empty & ~flush;
    // a bypassed entry is consumed in flight and never stored
    wr           = do_push & ~byp;
    overflow     = push & full & ~pop & ~flush;
    underflow    = pop & empty & ~flush & ~(p_bypass & push);
    rdata        = byp ? wdata : mem[rptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (wr)     wptr <= next_ptr(wptr);
      if (do_pop) rptr <= next_ptr(rptr);
      count <= count + CW'(wr) - CW'(do_pop);
    end
  end

  // storage is deliberately left out of reset and flush
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wdata;
  end

endmodule

// File: tb/tb_fifo_ext.sv
// Directed and randomised checks of fifo_ext across several depths, thresholds
// and bypass settings; all instances share one stimulus bus.
module tb_fifo_ext;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [31:0] wdata = '0;

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // instance index: 0 d4, 1 d3(af2,ae1), 2 d2, 3 d4 bypass, 4 d1, 5 d5(af3,ae2), 6 d32
  logic [31:0] rd [7];
  logic        em [7];
  logic        fu [7];
  logic        af [7];
  logic        ae [7];
  logic        ov [7];
  logic        un [7];
  logic [5:0]  ct [7];

  logic [2:0] ct0;
  logic [1:0] ct1;
  logic [1:0] ct2;
  logic [2:0] ct3;
  logic       ct4;
  logic [2:0] ct5;
  logic [5:0] ct6;

  assign ct[0] = {3'b0, ct0};
  assign ct[1] = {4'b0, ct1};
  assign ct[2] = {4'b0, ct2};
  assign ct[3] = {3'b0, ct3};
  assign ct[4] = {5'b0, ct4};
  assign ct[5] = {3'b0, ct5};
  assign ct[6] = ct6;

  fifo_ext #(.p_entry_bits(32), .p_depth(4)) u_d4 (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .pop(pop), .wdata(wdata),
    .rdata(rd[0]), .empty(em[0]), .full(fu[0]), .almost_full(af[0]), .almost_empty(ae[0]),
    .count(ct0), .overflow(ov[0]), .underflow(un[0]));

  fifo_ext #(.p_entry_bits(32), .p_depth(3), .p_almost_full(2), .p_almost_empty(1)) u_d3 (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .pop(pop), .wdata(wdata),
    .rdata(rd[1]), .empty(em[1]), .full(fu[1]), .almost_full(af[1]), .almost_empty(ae[1]),
    .count(ct1), .overflow(ov[1]), .underflow(un[1]));

  fifo_ext #(.p_entry_bits(32), .p_depth(2)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .pop(pop), .wdata(wdata),
    .rdata(rd[2]), .empty(em[2]), .full(fu[2]), .almost_full(af[2]), .almost_empty(ae[2]),
    .count(ct2), .overflow(ov[2]), .underflow(un[2]));

  fifo_ext #(.p_entry_bits(32), .p_depth(4), .p_bypass(1'b1)) u_byp (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .pop(pop), .wdata(wdata),
    .rdata(rd[3]), .empty(em[3]), .full(fu[3]), .almost_full(af[3]), .almost_empty(ae[3]),
    .count(ct3), .overflow(ov[3]), .underflow(un[3]));

  fifo_ext #(.p_entry_bits(32), .p_depth(1), .p_almost_full(1), .p_almost_empty(0)) u_d1 (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .pop(pop), .wdata(wdata),
    .rdata(rd[4]), .empty(em[4]), .full(fu[4]), .almost_full(af[4]), .almost_empty(ae[4]),
    .count(ct4), .overflow(ov[4]), .underflow(un[4]));

  fifo_ext #(.p_entry_bits(32), .p_depth(5), .p_almost_full(3), .p_almost_empty(2)) u_d5 (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .pop(pop), .wdata(wdata),
    .rdata(rd[5]), .empty(em[5]), .full(fu[5]), .almost_full(af[5]), .almost_empty(ae[5]),
    .count(ct5), .overflow(ov[5]), .underflow(un[5]));

  fifo_ext #(.p_entry_bits(32), .p_depth(32)) u_d32 (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .pop(pop), .wdata(wdata),
    .rdata(rd[6]), .empty(em[6]), .full(fu[6]), .almost_full(af[6]), .almost_empty(ae[6]),
    .count(ct6), .overflow(ov[6]), .underflow(un[6]));

  function automatic int dep(input int i);
    case (i)
      0: return 4;  1: return 3;  2: return 2;  3: return 4;
      4: return 1;  5: return 5;  default: return 32;
    endcase
  endfunction

  function automatic int afv(input int i);
    case (i)
      0: return 3;  1: return 2;  2: return 1;  3: return 3;
      4: return 1;  5: return 3;  default: return 31;
    endcase
  endfunction

  function automatic int aev(input int i);
    case (i)
      4: return 0;
      5: return 2;
      default: return 1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic p, input logic q, input logic f, input logic [31:0] d);
    @(negedge clk);
    push = p; pop = q; flush = f; wdata = d;
    #1;
  endtask

  // reference queue: circular buffer per instance
  logic [31:0] mm [7][32];
  int          mh [7];
  int          mc [7];

  task automatic model_step(input int i, input logic p, input logic q, input logic f,
                            input logic [31:0] d);
    int  dd = dep(i);
    int  c  = mc[i];
    logic e_full  = (c == dd);
    logic e_empty = (c == 0);
    logic dp, dq;
    check($sformatf("r%0d_cnt", i), ct[i], c);
    check($sformatf("r%0d_empty", i), em[i], e_empty);
    check($sformatf("r%0d_full", i), fu[i], e_full);
    check($sformatf("r%0d_afull", i), af[i], c >= afv(i));
    check($sformatf("r%0d_aempty", i), ae[i], c <= aev(i));
    check($sformatf("r%0d_ovf", i), ov[i], p & e_full & ~q & ~f);
    check($sformatf("r%0d_unf", i), un[i], q & e_empty & ~f);
    if (c > 0) check($sformatf("r%0d_rdata", i), rd[i], mm[i][mh[i]]);
    if (f) begin
      mc[i] = 0;
      mh[i] = 0;
    end else begin
      dp = p & (~e_full | q);
      dq = q & ~e_empty;
      if (dp) mm[i][(mh[i] + c) % dd] = d;
      if (dq) mh[i] = (mh[i] + 1) % dd;
      mc[i] = c + int'(dp) - int'(dq);
    end
  endtask

  initial begin
    int lst[4] = '{2, 4, 5, 6};
    logic p, q, f;
    logic [31:0] d;

    // reset values while rst held
    repeat (2) @(negedge clk);
    #1;
    check("rst_cnt", ct[0], 0);
    check("rst_empty", em[0], 1);
    check("rst_full", fu[0], 0);
    check("rst_aempty", ae[0], 1);
    check("rst_afull", af[0], 0);
    check("rst_ovf", ov[0], 0);
    check("rst_unf", un[0], 0);
    @(negedge clk);
    rst = 1'b0;

    // basic push/pop on depth 4
    drive(1, 0, 0, 32'hdeadbeef);
    drive(0, 0, 0, 0);
    check("basic_empty", em[0], 0);
    check("basic_cnt", ct[0], 1);
    check("basic_rdata", rd[0], 32'hdeadbeef);
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    check("basic_empty2", em[0], 1);
    check("basic_cnt2", ct[0], 0);

    // fill, overflow, thresholds and wrap on depth 3
    drive(0, 0, 1, 0);
    drive(1, 0, 0, 1);
    drive(1, 0, 0, 2);
    check("d3_cnt1", ct[1], 1);
    check("d3_af1", af[1], 0);
    check("d3_ae1", ae[1], 1);
    drive(1, 0, 0, 3);
    check("d3_cnt2", ct[1], 2);
    check("d3_af2", af[1], 1);
    check("d3_ae2", ae[1], 0);
    check("d3_full2", fu[1], 0);
    drive(1, 0, 0, 4);
    check("d3_full3", fu[1], 1);
    check("d3_ovf", ov[1], 1);
    drive(0, 0, 0, 0);
    check("d3_cnt_hold", ct[1], 3);
    check("d3_ovf_clr", ov[1], 0);
    check("d3_rd1", rd[1], 1);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    check("d3_rd2", rd[1], 2);
    check("d3_cnt_p1", ct[1], 2);
    check("d3_ae_p1", ae[1], 0);
    drive(0, 1, 0, 0);
    check("d3_rd3", rd[1], 3);
    check("d3_ae_p2", ae[1], 1);
    drive(1, 0, 0, 5);
    check("d3_empty", em[1], 1);
    drive(0, 1, 0, 0);
    check("d3_wrap_rd", rd[1], 5);
    check("d3_wrap_cnt", ct[1], 1);
    drive(0, 0, 0, 0);
    check("d3_wrap_empty", em[1], 1);

    // push+pop when full on depth 2
    drive(0, 0, 1, 0);
    drive(1, 0, 0, 7);
    drive(1, 0, 0, 8);
    drive(1, 1, 0, 9);
    check("d2_full", fu[2], 1);
    check("d2_ovf", ov[2], 0);
    check("d2_rd7", rd[2], 7);
    drive(0, 0, 0, 0);
    check("d2_cnt", ct[2], 2);
    check("d2_rd8", rd[2], 8);
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    check("d2_rd9", rd[2], 9);
    check("d2_cnt1", ct[2], 1);

    // push+pop when empty without bypass
    drive(0, 0, 1, 0);
    drive(1, 1, 0, 32'h55);
    check("nb_unf", un[2], 1);
    drive(0, 0, 0, 0);
    check("nb_cnt", ct[2], 1);
    check("nb_rd", rd[2], 32'h55);

    // bypass
    drive(0, 0, 1, 0);
    drive(1, 1, 0, 32'habc);
    check("byp_rd", rd[3], 32'habc);
    check("byp_unf", un[3], 0);
    check("byp_cnt", ct[3], 0);
    drive(0, 0, 0, 0);
    check("byp_cnt2", ct[3], 0);
    check("byp_empty", em[3], 1);

    // flush with push asserted
    drive(0, 0, 1, 0);
    drive(1, 0, 0, 32'ha);
    drive(1, 0, 0, 32'hb);
    drive(1, 0, 1, 32'hc);
    check("fl_cnt_pre", ct[0], 2);
    check("fl_ovf", ov[0], 0);
    drive(0, 0, 0, 0);
    check("fl_cnt", ct[0], 0);
    check("fl_empty", em[0], 1);
    drive(1, 0, 0, 32'hd);
    drive(0, 0, 0, 0);
    check("fl_rd", rd[0], 32'hd);
    check("fl_cnt1", ct[0], 1);

    // asynchronous reset mid-stream
    drive(0, 0, 1, 0);
    drive(1, 0, 0, 32'h21);
    drive(1, 0, 0, 32'h22);
    drive(1, 0, 0, 32'h23);
    drive(0, 0, 0, 0);
    check("ar_cnt_pre", ct[0], 3);
    #1 rst = 1'b1;
    #1;
    check("ar_cnt", ct[0], 0);
    check("ar_empty", em[0], 1);
    check("ar_full", fu[0], 0);
    check("ar_aempty", ae[0], 1);
    check("ar_afull", af[0], 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0, 32'h11);
    drive(0, 1, 0, 0);
    check("ar_rd", rd[0], 32'h11);
    drive(0, 0, 0, 0);
    check("ar_empty2", em[0], 1);

    // random traffic against the reference queues
    drive(0, 0, 1, 0);
    for (int i = 0; i < 7; i++) begin
      mc[i] = 0;
      mh[i] = 0;
    end
    for (int t = 0; t < 200; t++) begin
      p = ($urandom_range(0, 99) < 60);
      q = ($urandom_range(0, 99) < 45);
      f = ($urandom_range(0, 99) < 3);
      d = $urandom;
      drive(p, q, f, d);
      foreach (lst[k]) model_step(lst[k], p, q, f, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/fifo_ext.md
# fifo_ext

Parametrised synchronous FIFO, the successor to the team's basic push/pop FIFO. It adds:

- an occupancy count;
- programmable almost-full and almost-empty thresholds;
- a synchronous flush;
- overflow and underflow indications;
- an optional same-cycle bypass mode.

It sits between decoupled pipeline stages and request/response queues where producers need early back-pressure (almost_full) and consumers need queue draining on squash (flush).

## Interface

Parameters:
- p_entry_bits, 32, width of one entry.
- p_depth, 32, number of entries. Any value ≥ 1; a power of two is not required.
- p_almost_full, p_depth-1, almost_full asserts when count ≥ this value. Legal range 1..p_depth.
- p_almost_empty, 1, almost_empty asserts when count ≤ this value. Legal range 0..p_depth-1.
- p_bypass, 0, set to 1 to enable empty-queue pass-through.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- flush  input  1  synchronous clear of all entries.
- push  input  1  enqueue wdata this cycle.
- pop  input  1  dequeue the head entry this cycle.
- wdata  input  p_entry_bits  write data.
- rdata  output  p_entry_bits  head entry (or bypassed wdata).
- empty  output  1  count == 0.
- full  output  1  count == p_depth.
- almost_full  output  1  count ≥ p_almost_full.
- almost_empty  output  1  count ≤ p_almost_empty.
- count  output  $clog2(p_depth+1)  current occupancy.
- overflow  output  1  push dropped this cycle.
- underflow  output  1  pop dropped this cycle.

## Operation

State:
- storage array of p_depth entries;
- read pointer and write pointer, each 0..p_depth-1, wrapping explicitly at p_depth-1 to 0 (no power-of-two masking);
- count register.

All status outputs are combinational from count and the current inputs only; no status output depends on storage contents.

Accepted operations per cycle:
- do_push = push & (~full | pop): a push into a full queue succeeds if a pop happens in the same cycle.
- do_pop = pop & ~empty.

Bypass case (p_bypass=1, empty, push and pop in the same cycle):
- rdata = wdata combinationally and the pop is accepted.
- Nothing is written, no pointer moves, count stays 0.
- underflow stays 0.

Count update: count_next = count + do_push − do_pop. The update is never reached when full with no pop, or empty with no push.

Flush has highest priority:
- Pointers and count go to 0 next edge.
- push and pop in that cycle are ignored.
- overflow and underflow read 0.
- Storage contents are not cleared.

Error indications (combinational, informational only; state is unaffected):
- overflow = push & full & ~pop & ~flush.
- underflow = pop & empty & ~flush & ~(p_bypass & push).

rdata:
- When non-empty: storage[read pointer].
- When empty with bypass inactive: don't-care; the bench must not check it.

## Timing

- Reset (asynchronous assert; deassert synchronous to clk): count=0, pointers=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, rdata don't-care.
- Push-to-visible latency: 1 cycle. An entry pushed at edge N appears on rdata, with empty=0, after edge N.
- Pop: the head advances at the edge where do_pop is true. rdata shows the next entry after that edge.
- Bypass latency: 0 cycles (combinational wdata→rdata).
- p_depth=1:
  - Pointers are always 0.
  - full and ~empty coincide.
  - A push and pop while full replaces the entry; rdata shows the new value after the edge.
- Reset asserted mid-operation: immediate return to reset state, with no clock edge needed.

## Test plan

- Basic, p_depth=4, p_entry_bits=32:
  - push 0xdeadbeef → next cycle empty=0, count=1, rdata=0xdeadbeef.
  - pop → empty=1, count=0.
- Fill, wrap and thresholds, p_depth=3, p_almost_full=2, p_almost_empty=1:
  - push 1,2,3 → count reaches 3 with full=1; almost_full rises when count=2.
  - push 4 with no pop → overflow=1, count stays 3.
  - pop ×3 → rdata 1,2,3; almost_empty rises at count=1.
  - push 5, pop → rdata=5 (pointer wrap).
- Simultaneous push and pop:
  - when full, p_depth=2 holding {7,8}: push 9 + pop → count stays 2, next rdata=8, then 9.
  - when empty with p_bypass=0: underflow=1, count becomes 1, rdata=push data next cycle.
- Bypass, p_bypass=1, empty queue, push 0xabc + pop → rdata=0xabc that cycle, count stays 0, underflow=0.
- Flush with count=2 and push=1 asserted → next cycle count=0, empty=1; the pushed value is not enqueued.
- Reset mid-stream (count=3): assert rst between edges → outputs return to reset values immediately. After release, push 0x11 then pop → rdata=0x11.
- Random, 200 cycles, against a queue model across p_depth ∈ {1,2,5,32}: check count, empty, full, both thresholds, overflow and underflow every cycle; check rdata whenever non-empty.
